product_bcd: RTL
================

# product_bcd

Sequential signed-binary-to-BCD converter sitting directly downstream of the 8x8 add-shift multiplier. On a Start pulse it captures the 16-bit two's-complement product {A, B}, takes its magnitude, and runs a 16-iteration double-dabble. It then presents a sign flag plus five BCD digits for the decimal display path. Start/Busy/Done handshake; the result is held until the next conversion completes.

## Interface
- W, 16, input width in bits; also the number of double-dabble iterations.
- D, 5, number of BCD digits out. Must satisfy 10^D > 2^(W-1).
- Clk  in  1  system clock, rising-edge.
- Reset  in  1  asynchronous, active-low reset; clears all state and outputs immediately.
- Start  in  1  synchronous request, already synchronized upstream; sampled only in IDLE.
- Prod  in  W  two's-complement product, i.e. {A, B} from the multiplier; sampled on the accepting edge only.
- Busy  out  1  high while a conversion is in progress.
- Done  out  1  one-cycle pulse marking a new, valid Sign/Bcd.
- Sign  out  1  1 = result negative.
- Bcd  out  4*D  magnitude in BCD; digit 0 is Bcd[3:0] (least significant).

## Operation
- States: IDLE, LOAD, CONV.
- IDLE, Start=1 → LOAD. Capture Prod into the operand register and raise Busy.
- LOAD → CONV, unconditionally:
  - sign_r = op[W-1].
  - mag = op[W-1] ? (~op + 1) : op, as a W-bit unsigned value. 0x8000 yields 32768, correct in W bits.
  - BCD scratch = 0; iteration counter = 0.
- CONV, one iteration per cycle:
  - Add-3 step on the scratch: any 4-bit digit ≥ 5 gets +3. All digits are evaluated in parallel from the pre-add scratch value.
  - Shift step: shift the concatenation {scratch, mag} left by 1; mag LSB fills with 0.
  - Counter increments after each iteration.
- CONV exit, on the edge where counter == W-1:
  - The final iteration's result is written to the Bcd output register; Sign is updated from sign_r.
  - Done = 1 for exactly one cycle; Busy = 0.
  - State → IDLE.
- Sign/Bcd change only on that completion edge. They hold their value through later conversions until the next completion.
- Start while in LOAD or CONV is ignored: not queued, no effect on the conversion in progress.
- Prod may change freely after the accepting edge; the result reflects the captured value.
- Zero result: Sign = 0, Bcd = 0. Negative zero cannot occur.
- Reset asserted (low) in any state:
  - Immediately: state = IDLE; Busy, Done, Sign, Bcd, operand, scratch and counter all = 0.
  - Any in-flight conversion is discarded.
  - After deassertion, the first Start begins a clean conversion.

## Timing
- Edge 0 is the rising edge that samples Start=1 in IDLE.
- Busy goes high after edge 0 and falls after edge W+1 (edge 17 for W=16).
- Edge 1: LOAD → CONV.
- Edges 2..W+1: the W iterations.
- After edge W+1, Bcd/Sign are valid and Done = 1 for one cycle.
- Latency: W+1 cycles from the accepting edge to Done (17 cycles at W=16).
- State is IDLE during the Done cycle, so Start held high is re-accepted at edge W+2. Back-to-back throughput is one conversion per W+2 cycles.
- Reset values of all outputs: Busy 0, Done 0, Sign 0, Bcd 0.
- Outputs are registered; there is no combinational path from Start or Prod to any output.

## Test plan
- Reset, then Prod=0x0000 with a 1-cycle Start → Done after edge 17; Sign=0, Bcd=0x00000; Busy high for exactly 17 cycles.
- Prod=0x3F01 (127·127=16129) → Sign=0, Bcd=0x16129. Then Prod=0xC080 (−128·127=−16256) → Sign=1, Bcd=0x16256. Bcd holds 0x16129 until the second Done.
- Extremes: Prod=0x8000 → Sign=1, Bcd=0x32768. Prod=0x7FFF → Sign=0, Bcd=0x32767. Prod=0xFFFF → Sign=1, Bcd=0x00001.
- Start held high with Prod=0x4000 (16384):
  - First Done after edge 17 with Bcd=0x16384.
  - Prod changed to 0x0001 at edge 5 → that conversion is unaffected.
  - Re-accept at edge 18 → next Done after edge 35 with Bcd=0x00001.
  - Done is never asserted two cycles in a row.
- Reset pulled low mid-CONV (at edge 8) → Busy, Done, Sign, Bcd read 0 before the next edge. Release reset, Start with Prod=0xFF81 (−127) → Sign=1, Bcd=0x00127, 17 cycles after acceptance.
- Randomized sweep of all 8x8 signed operand pairs: Prod = a·b → Sign and Bcd match a reference decimal conversion of a·b for every pair.

Source files
------------

// File: rtl/product_bcd.sv
// product_bcd
//   Sequential signed-binary to BCD converter. Captures a W-bit two's-complement
//   product on a Start pulse, takes its magnitude and runs a W-iteration
//   double-dabble, one iteration per clock. Result (sign + D BCD digits) is held
//   until the next conversion completes.
//
// Ports
//   i_clk    : system clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_start  : conversion request, sampled only in IDLE
//   i_prod   : W-bit two's-complement product, sampled on the accepting edge
//   o_busy   : high while a conversion is in progress
//   o_done   : one-cycle pulse marking a new o_sign/o_bcd
//   o_sign   : 1 = result negative
//   o_bcd    : 4*D-bit BCD magnitude, digit 0 in o_bcd[3:0]
module product_bcd #(
  parameter int W = 16,
  parameter int D = 5   // needs 10^D > 2^(W-1)
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic [W-1:0]   i_prod,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_sign,
  output logic [4*D-1:0] o_bcd
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CONV = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [W-1:0]          r_op;
  logic                  r_sign;
  logic [W-1:0]          r_mag;
  logic [D-1:0][3:0]     r_scr;
  logic [CW-1:0]         r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_sign_o;
  logic [4*D-1:0]        r_bcd;

  logic [D-1:0][3:0]     w_adj;
  logic [4*D-1:0]        w_adj_flat;
  logic [4*D-1:0]        w_scr_nxt;
  logic [W-1:0]          w_mag_nxt;
  logic [W-1:0]          w_abs;
  logic                  w_last;

  // Add-3 correction, every digit in parallel from the pre-add scratch.
  for (genvar g = 0; g < D; g++) begin : g_dig
    assign w_adj[g] = (r_scr[g] >= 4'd5) ? (r_scr[g] + 4'd3) : r_scr[g];
  end

  // Shift {scratch, mag} left by one; the mag MSB moves into digit 0.
  assign w_adj_flat = w_adj;
  assign w_scr_nxt  = {w_adj_flat[4*D-2:0], r_mag[W-1]};
  assign w_mag_nxt  = {r_mag[W-2:0], 1'b0};

  // Magnitude in W unsigned bits: the most negative value maps to 2^(W-1),
  // which still fits.
  assign w_abs  = r_op[W-1] ? ((~r_op) + W'(1)) : r_op;
  assign w_last = (r_cnt == CNT_LAST);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_CONV;
      S_CONV:  if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op     <= '0;
      r_sign   <= 1'b0;
      r_mag    <= '0;
      r_scr    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sign_o <= 1'b0;
      r_bcd    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op   <= i_prod;
            r_busy <= 1'b1;
          end
        end
        S_LOAD: begin
          r_sign <= r_op[W-1];
          r_mag  <= w_abs;
          r_scr  <= '0;
          r_cnt  <= '0;
        end
        S_CONV: begin
          r_scr <= w_scr_nxt;
          r_mag <= w_mag_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            // Final iteration goes straight to the output register so the
            // result appears together with Done.
            r_bcd    <= w_scr_nxt;
            r_sign_o <= r_sign;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_sign = r_sign_o;
  assign o_bcd  = r_bcd;

endmodule
